// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle handshake: synchronises req_tog, holds each
// transfer for a valid/ready consumer and returns completion on ack_tog.
module toggle_handshake_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  input  logic              clr_overrun,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              ack_tog,
  output logic              overrun,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   tog_det;
  logic                   capture;
  logic                   accept;

  // prev tracks the synchronised level every cycle, so an edge seen while
  // holding is consumed here and never replayed once the FSM returns to IDLE.
  assign tog_det = sync[SYNC_STAGES-1] ^ prev;
  assign valid   = (state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tog_det) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      prev     <= 1'b0;
      data_out <= '0;
      ack_tog  <= 1'b0;
      xfer_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_tog};
      prev <= sync[SYNC_STAGES-1];
      if (capture) begin
        data_out <= data_in;
      end
      if (accept) begin
        ack_tog  <= ~ack_tog;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (tog_det && (state == HOLD)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: data words are queued when a toggle is
// sent and checked against data_out when the receiver presents them.
module tb_toggle_handshake_rx;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_tog;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              clr_overrun;
  logic              valid;
  logic [DATA_W-1:0] data_out;
  logic              ack_tog;
  logic              overrun;
  logic [CNT_W-1:0]  xfer_cnt;

  int unsigned       vectors = 0;
  int unsigned       errors  = 0;
  logic [DATA_W-1:0] sb[$];
  logic [CNT_W-1:0]  exp_cnt;
  logic              exp_ack;
  logic [DATA_W-1:0] held;

  toggle_handshake_rx #(
    .DATA_W(DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_tog(req_tog),
    .data_in(data_in),
    .ready(ready),
    .clr_overrun(clr_overrun),
    .valid(valid),
    .data_out(data_out),
    .ack_tog(ack_tog),
    .overrun(overrun),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for valid after a toggle, check latency and the scoreboard word.
  task automatic wait_valid(input string tag);
    int unsigned lat = 0;
    logic [DATA_W-1:0] exp_d;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, SYNC_STAGES + 1);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
    held  = exp_d;
    chk({tag, "_data"}, data_out, exp_d);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    data_in = d;
    req_tog = ~req_tog;
    sb.push_back(d);
  endtask

  task automatic check_accept(input string tag);
    exp_ack = ~exp_ack;
    exp_cnt = exp_cnt + CNT_W'(1);
    chk({tag, "_valid_low"}, valid, 0);
    chk({tag, "_ack"}, ack_tog, exp_ack);
    chk({tag, "_cnt"}, xfer_cnt, exp_cnt);
  endtask

  task automatic xfer(input string tag, input logic [DATA_W-1:0] d, input int unsigned stall);
    ready = (stall == 0);
    send(d);
    wait_valid(tag);
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_valid"}, valid, 1);
      chk({tag, "_stall_data"}, data_out, d);
      chk({tag, "_stall_ack"}, ack_tog, exp_ack);
    end
    ready = 1'b1;
    tick();
    check_accept(tag);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    req_tog = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    exp_ack = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset       = 1'b1;
    req_tog     = 1'b0;
    data_in     = '0;
    ready       = 1'b0;
    clr_overrun = 1'b0;
    exp_cnt     = '0;
    exp_ack     = 1'b0;
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ack", ack_tog, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt", xfer_cnt, 0);
    reset = 1'b0;
    tick();

    // Single transfer, then backpressure.
    xfer("single", 8'hA5, 0);
    tick();
    xfer("bp", 8'h5C, 5);
    tick();

    // Overrun: second toggle while 0x11 is stalled.
    ready = 1'b0;
    send(8'h11);
    wait_valid("ovr");
    data_in = 8'h3C;
    req_tog = ~req_tog;
    tick();
    tick();
    chk("ovr_not_yet", overrun, 0);
    tick();
    chk("ovr_set", overrun, 1);
    chk("ovr_data_kept", data_out, 8'h11);
    chk("ovr_valid_held", valid, 1);
    ready = 1'b1;
    tick();
    check_accept("ovr");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ovr_dropped_valid", valid, 0);
    end
    chk("ovr_cnt_once", xfer_cnt, exp_cnt);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Acceptance, new toggle and clear all land on the same edge.
    ready = 1'b0;
    send(8'h22);
    wait_valid("sim");
    data_in = 8'h44;
    req_tog = ~req_tog;
    tick();
    tick();
    ready       = 1'b1;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check_accept("sim");
    chk("sim_set_wins", overrun, 1);
    chk("sim_data_kept", data_out, 8'h22);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sim_dropped_valid", valid, 0);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("sim_cleared", overrun, 0);

    // Counter wrap over 257 back-to-back transfers from a fresh reset.
    do_reset();
    tick();
    for (int unsigned n = 0; n < 257; n++) begin
      xfer("wrap", DATA_W'($urandom), (n % 37 == 5) ? 2 : 0);
      chk("wrap_dir", ack_tog, req_tog);
    end
    chk("wrap_final_cnt", xfer_cnt, 1);

    // Asynchronous reset while a word is held.
    ready = 1'b0;
    send(8'h5A);
    wait_valid("arst_pre");
    #3;
    reset   = 1'b1;
    req_tog = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_ack", ack_tog, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_cnt", xfer_cnt, 0);
    tick();
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    exp_ack = 1'b0;
    sb.delete();
    data_in = 8'h77;
    sb.push_back(8'h77);
    ready = 1'b1;
    wait_valid("arst_post");
    tick();
    check_accept("arst_post");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_single_valid", valid, 0);
    end
    chk("arst_single_cnt", xfer_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receiving end of the team's two-phase toggle handshake. The sender owns a toggle flop that inverts `req_tog` once per transfer. This block:
- synchronises `req_tog` into the local clock domain;
- decodes each transition into a single held transfer, captures the accompanying data word and presents it to a local consumer with a valid/ready handshake;
- returns completion by toggling `ack_tog`.

It sits between a toggle-flop based transmitter and downstream logic, and also keeps a transfer count and a sticky overrun flag.

## Interface
- `DATA_W`, 8, width of the data word carried with each toggle.
- `SYNC_STAGES`, 2, flops in the `req_tog` synchroniser chain (legal 2..4).
- `CNT_W`, 8, width of the accepted-transfer counter.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  reset, asynchronous and active-high; all registers cleared immediately.
- `req_tog`  input  1  request toggle from the sender; every 0->1 or 1->0 transition is one transfer.
- `data_in`  input  `DATA_W`  sender data; stable from before the `req_tog` transition until `ack_tog` returns.
- `ready`  input  1  consumer can accept `data_out` this cycle.
- `clr_overrun`  input  1  synchronous clear of `overrun`.
- `valid`  output  1  `data_out` holds an unconsumed transfer.
- `data_out`  output  `DATA_W`  captured data word.
- `ack_tog`  output  1  acknowledge toggle; inverts once per accepted transfer.
- `overrun`  output  1  sticky: a toggle arrived while a transfer was still held.
- `xfer_cnt`  output  `CNT_W`  number of accepted transfers, modulo 2^`CNT_W`.

## Operation
- Synchroniser: `sync[0] <= req_tog`, `sync[i] <= sync[i-1]`. The register `prev` holds the last decoded level. Define `tog_det = sync[SYNC_STAGES-1] ^ prev`.
- `prev` is loaded with `sync[SYNC_STAGES-1]` every cycle. Each transition therefore yields exactly one `tog_det` cycle, whatever the state.
- FSM with two states, IDLE and HOLD:
  - IDLE, `tog_det`=1: capture `data_out <= data_in`, set `valid`=1, go to HOLD.
  - HOLD, `ready`=1: `valid`=0, `ack_tog` inverts, `xfer_cnt` increments, go to IDLE.
  - HOLD, `ready`=0: hold `data_out` and `valid`.
- Overrun: `tog_det`=1 while in HOLD sets `overrun`=1. In this case:
  - the new event is dropped;
  - `data_out` is not overwritten;
  - `xfer_cnt` is not incremented for it.
  - This applies even if `ready`=1 in the same cycle: the held transfer is accepted normally and the new toggle is still dropped.
- `clr_overrun`=1 clears `overrun` next edge. If a new overrun occurs in the same cycle, set wins.
- `xfer_cnt` wraps from 2^`CNT_W`-1 to 0 without a flag.
- Reset values:
  - `sync`, `prev`, `ack_tog`, `valid`, `overrun` = 0;
  - `data_out` = 0;
  - `xfer_cnt` = 0;
  - FSM = IDLE.
- Reset mid-transfer discards the held word without toggling `ack_tog`. If `req_tog`=1 after reset release, that level counts as one pending transition and is decoded as a transfer.

## Timing
- Decode latency: `req_tog` changes before edge k, so `valid` rises at edge k+`SYNC_STAGES`. With the default of 2, `valid` is high two cycles after the first sampling edge.
- `data_in` is sampled on the same edge `valid` rises.
- Acceptance: `valid`&`ready` high at edge m means `valid` is low, `ack_tog` is toggled and `xfer_cnt` is incremented after edge m.
- A toggle decoded the cycle after acceptance is legal: IDLE re-captures. Minimum back-to-back spacing is one idle cycle between `valid` pulses.
- `ack_tog` and `valid` are registered outputs with no combinational path from inputs.
- Two `req_tog` transitions closer than one clock may be lost. The sender protocol forbids this by waiting for the `ack_tog` change.

## Test plan
- Reset and single transfer:
  - stimulus: reset, then `req_tog` 0->1 with `data_in`=0xA5, `ready`=1;
  - required: `valid` high at edge `SYNC_STAGES` after sampling, `data_out`=0xA5, `ack_tog`=1 and `xfer_cnt`=1 the next cycle.
- Backpressure:
  - stimulus: `ready`=0 for 5 cycles after `valid`, then 1;
  - required: `valid` and `data_out` stable for those 5 cycles, a single `ack_tog` toggle, `xfer_cnt` +1.
- Overrun:
  - stimulus: second `req_tog` toggle with `data_in`=0x3C while held word 0x11 is stalled;
  - required: `overrun`=1, `data_out` stays 0x11, `xfer_cnt` increments once only, then `clr_overrun` returns `overrun` to 0.
- Wrap and direction:
  - stimulus: 257 handshaked transfers alternating 0->1 and 1->0, `CNT_W`=8;
  - required: `xfer_cnt`=1 at the end, `ack_tog` equals `req_tog` after every completion.
- Async reset mid-HOLD:
  - stimulus: assert `reset` between edges while `valid`=1;
  - required: all outputs 0 immediately with no `ack_tog` toggle; after release with `req_tog`=1, exactly one transfer is decoded.
- Simultaneous events:
  - stimulus: `ready`=1 and a new toggle decoded in the same HOLD cycle, together with `clr_overrun`=1;
  - required: held word accepted, new event dropped, `overrun`=1 (set wins).
